// File: rtl/serial_decode_unit_pkg.sv
// serial_decode_unit_pkg: shared control bundles and source/adder selects for the serial decode stage.
package serial_decode_unit_pkg;
  typedef enum logic [1:0] {SRC_IMM, SRC_REG, SRC_PC} ser_src_e;
  typedef enum logic {ADD_SEL_PC, ADD_SEL_REG} add_sel_e;
  typedef struct packed {
    logic alu_a;
    logic wb;
    logic lsu_addr;
    logic jmp;
    logic branch;
    logic reg_use;
    logic load_bypass;
  } dec_en_s;
  typedef struct packed {
    ser_src_e src_sel;
    add_sel_e add_sel;
    logic     msb_first;
    dec_en_s  en;
  } dec_cs_s;
  typedef struct packed {
    logic rf_write;
    logic dmem_store;
    logic wb_order_flip;
  } exe_en_s;
  typedef struct packed {
    logic [3:0] alu_op;
    exe_en_s    en;
  } exe_cs_s;
  function automatic int cnt_w(input int nbeats);
    return nbeats > 1 ? $clog2(nbeats) : 1;
  endfunction
endpackage

// File: rtl/serial_decode_unit_beat_serializer.sv
// beat_serializer: picks beat idx_i (SER_W bits wide) out of an XLEN-wide operand.
module beat_serializer
  import serial_decode_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SER_W = 16,
  localparam int CNT_W = cnt_w(XLEN / SER_W)
) (
  input  logic [XLEN-1:0]  src_i,
  input  logic [CNT_W-1:0] idx_i,
  output logic [SER_W-1:0] beat_o
);
  assign beat_o = SER_W'(src_i >> (idx_i * SER_W));
endmodule

// File: rtl/serial_decode_unit.sv
// serial_decode_unit: issues one XLEN operand as NBEATS serial beats, with RAW/load-bypass stall,
// address adder and registered execute-side outputs.
module serial_decode_unit
  import serial_decode_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SER_W = 16,
  localparam int NBEATS = XLEN / SER_W,
  localparam int CNT_W = cnt_w(NBEATS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic             ready_i,
  input  logic [31:0]      inst_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  reg1_i,
  input  logic [XLEN-1:0]  imm_i,
  input  dec_cs_s          cs_dec_i,
  input  exe_cs_s          cs_exe_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [SER_W-1:0] beat_o,
  output logic [CNT_W-1:0] beat_idx_o,
  output logic             beat_last_o,
  output exe_cs_s          cs_exe_o,
  output logic [XLEN-1:0]  lsu_addr_o,
  output logic             jmp_o,
  output logic             branch_o,
  output logic [XLEN-1:0]  jmp_target_o,
  output logic [4:0]       rd_o,
  output logic [4:0]       rs1_o,
  output logic [4:0]       rs2_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBEATS - 1);
  if (XLEN % SER_W != 0) begin : g_bad_ser_w
    $error("SER_W must divide XLEN");
  end
  logic [CNT_W-1:0] cnt_q, cnt_d, idx, beat_idx_q;
  logic             ready_i_q, stall, advance, last, beat_last_q;
  logic [XLEN-1:0]  src, add_out, lsu_addr_q;
  logic [4:0]       rd, rs1, rs2, rd_q, rs1_q, rs2_q;
  logic [SER_W-1:0] beat, beat_q;
  exe_cs_s          cs_exe_q;
  logic             unused_inst;
  assign unused_inst = ^{inst_i[31:25], inst_i[14:12], inst_i[6:0]};
  always_comb begin
    rd = inst_i[11:7];
    rs1 = inst_i[19:15];
    rs2 = inst_i[24:20];
    last = cnt_q == LAST;
    // hazards are only honoured while the previous cycle's ready_i was low
    stall = !ready_i_q &&
            ((cs_dec_i.en.load_bypass && !cs_exe_q.en.dmem_store) ||
             (cs_exe_q.en.rf_write && rd_q == rs1 && rs1 != 5'd0) ||
             (cs_dec_i.en.alu_a && cs_exe_q.en.wb_order_flip && rd_q == rs2));
    advance = valid_i && ready_i && !stall;
    cnt_d = !valid_i ? '0 : !advance ? cnt_q : last ? '0 : cnt_q + CNT_W'(1);
    idx = cs_dec_i.msb_first ? LAST - cnt_q : cnt_q;
    src = cs_dec_i.src_sel == SRC_IMM ? imm_i : cs_dec_i.src_sel == SRC_PC ? pc_i : reg1_i;
    add_out = (cs_dec_i.add_sel == ADD_SEL_PC ? pc_i : reg1_i) + imm_i;
  end
  beat_serializer #(.XLEN(XLEN), .SER_W(SER_W)) u_ser (
    .src_i (src),
    .idx_i (idx),
    .beat_o(beat)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ready_i_q <= 1'b0;
      beat_q <= '0;
      beat_idx_q <= '0;
      beat_last_q <= 1'b0;
      lsu_addr_q <= '0;
      rd_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      cs_exe_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ready_i_q <= ready_i;
      if (cs_dec_i.en.reg_use) rs1_q <= rs1;
      if (advance) begin
        cs_exe_q <= cs_exe_i;
        if (cs_dec_i.en.alu_a || cs_dec_i.en.wb) begin
          beat_q <= beat;
          beat_idx_q <= idx;
          beat_last_q <= last;
        end
        if (cnt_q == '0) begin
          if (cs_dec_i.en.lsu_addr) lsu_addr_q <= add_out;
          if (cs_exe_i.en.rf_write) rd_q <= rd;
          if (cs_dec_i.en.alu_a) rs2_q <= rs2;
        end
      end
    end
  end
  assign ready_o = advance && last;
  assign valid_o = valid_i;
  assign beat_o = beat_q;
  assign beat_idx_o = beat_idx_q;
  assign beat_last_o = beat_last_q;
  assign cs_exe_o = cs_exe_q;
  assign lsu_addr_o = lsu_addr_q;
  assign jmp_o = valid_i && cnt_q == '0 && cs_dec_i.en.jmp;
  assign branch_o = valid_i && cnt_q == '0 && cs_dec_i.en.branch;
  assign jmp_target_o = add_out;
  assign rd_o = rd_q;
  assign rs1_o = cs_dec_i.en.reg_use ? rs1 : rs1_q;
  assign rs2_o = rs2_q;
endmodule

// File: tb/tb_serial_decode_unit.sv
// tb_serial_decode_unit: directed scenarios plus a randomized run against a behavioural model,
// on two instances (16-bit and 8-bit beats) driven by the same inputs.
module tb_serial_decode_unit;
  import serial_decode_unit_pkg::*;
  logic clk = 0, rst_n = 0, valid_i = 0, ready_i = 0;
  logic [31:0] inst_i = 0, pc_i = 0, reg1_i = 0, imm_i = 0;
  dec_cs_s cs_dec_i = '0;
  exe_cs_s cs_exe_i = '0;
  logic ready_a, valid_a, last_a, jmp_a, br_a;
  logic [15:0] beat_a;
  logic [0:0] idx_a;
  exe_cs_s exe_a;
  logic [31:0] lsu_a, tgt_a;
  logic [4:0] rd_a, rs1_a, rs2_a;
  logic ready_b, valid_b, last_b, jmp_b, br_b;
  logic [7:0] beat_b;
  logic [1:0] idx_b;
  exe_cs_s exe_b;
  logic [31:0] lsu_b, tgt_b;
  logic [4:0] rd_b, rs1_b, rs2_b;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  serial_decode_unit #(.XLEN(32), .SER_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_i(ready_i), .inst_i(inst_i),
    .pc_i(pc_i), .reg1_i(reg1_i), .imm_i(imm_i), .cs_dec_i(cs_dec_i), .cs_exe_i(cs_exe_i),
    .ready_o(ready_a), .valid_o(valid_a), .beat_o(beat_a), .beat_idx_o(idx_a),
    .beat_last_o(last_a), .cs_exe_o(exe_a), .lsu_addr_o(lsu_a), .jmp_o(jmp_a),
    .branch_o(br_a), .jmp_target_o(tgt_a), .rd_o(rd_a), .rs1_o(rs1_a), .rs2_o(rs2_a)
  );
  serial_decode_unit #(.XLEN(32), .SER_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_i(ready_i), .inst_i(inst_i),
    .pc_i(pc_i), .reg1_i(reg1_i), .imm_i(imm_i), .cs_dec_i(cs_dec_i), .cs_exe_i(cs_exe_i),
    .ready_o(ready_b), .valid_o(valid_b), .beat_o(beat_b), .beat_idx_o(idx_b),
    .beat_last_o(last_b), .cs_exe_o(exe_b), .lsu_addr_o(lsu_b), .jmp_o(jmp_b),
    .branch_o(br_b), .jmp_target_o(tgt_b), .rd_o(rd_b), .rs1_o(rs1_b), .rs2_o(rs2_b)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    valid_i = 0; ready_i = 1; cs_dec_i = '0; cs_exe_i = '0; inst_i = 0;
    tick;
  endtask
  task automatic test_reset;
    #2;
    checks++; if (beat_a !== 16'h0) begin errs++; $display("FAIL rst_beat_a got=%h exp=0", beat_a); end
    checks++; if (beat_b !== 8'h0) begin errs++; $display("FAIL rst_beat_b got=%h exp=0", beat_b); end
    checks++; if (idx_b !== 2'd0) begin errs++; $display("FAIL rst_idx_b got=%h exp=0", idx_b); end
    checks++; if (last_a !== 1'b0) begin errs++; $display("FAIL rst_last_a got=%b exp=0", last_a); end
    checks++; if (exe_a !== '0) begin errs++; $display("FAIL rst_exe_a got=%h exp=0", exe_a); end
    checks++; if (lsu_a !== 32'h0) begin errs++; $display("FAIL rst_lsu_a got=%h exp=0", lsu_a); end
    checks++; if ({rd_a, rs1_a, rs2_a} !== 15'h0) begin errs++; $display("FAIL rst_regs_a got=%h exp=0", {rd_a, rs1_a, rs2_a}); end
    checks++; if ({ready_a, jmp_a, br_a} !== 3'b0) begin errs++; $display("FAIL rst_strobes_a got=%b exp=0", {ready_a, jmp_a, br_a}); end
    #1 rst_n = 1;
  endtask
  task automatic test_lsb16;
    idle;
    cs_dec_i.src_sel = SRC_REG; cs_dec_i.en.alu_a = 1; reg1_i = 32'hDEADBEEF; valid_i = 1;
    #1;
    checks++; if (ready_a !== 1'b0) begin errs++; $display("FAIL lsb16_ready_c1 got=%b exp=0", ready_a); end
    tick;
    checks++; if (beat_a !== 16'hBEEF) begin errs++; $display("FAIL lsb16_beat0 got=%h exp=beef", beat_a); end
    checks++; if ({idx_a, last_a} !== 2'b00) begin errs++; $display("FAIL lsb16_idx_last0 got=%b exp=00", {idx_a, last_a}); end
    checks++; if (ready_a !== 1'b1) begin errs++; $display("FAIL lsb16_ready_c2 got=%b exp=1", ready_a); end
    tick;
    checks++; if (beat_a !== 16'hDEAD) begin errs++; $display("FAIL lsb16_beat1 got=%h exp=dead", beat_a); end
    checks++; if ({idx_a, last_a} !== 2'b11) begin errs++; $display("FAIL lsb16_idx_last1 got=%b exp=11", {idx_a, last_a}); end
    valid_i = 0;
  endtask
  task automatic test_msb8;
    logic [7:0] exp_b[4];
    exp_b = '{8'h12, 8'h34, 8'h56, 8'h78};
    idle;
    cs_dec_i.src_sel = SRC_IMM; cs_dec_i.msb_first = 1; cs_dec_i.en.alu_a = 1;
    imm_i = 32'h12345678; valid_i = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (ready_b !== (k == 3)) begin errs++; $display("FAIL msb8_ready k=%0d got=%b exp=%b", k, ready_b, k == 3); end
      tick;
      checks++; if (beat_b !== exp_b[k]) begin errs++; $display("FAIL msb8_beat k=%0d got=%h exp=%h", k, beat_b, exp_b[k]); end
      checks++; if (idx_b !== 2'(3 - k)) begin errs++; $display("FAIL msb8_idx k=%0d got=%0d exp=%0d", k, idx_b, 3 - k); end
      checks++; if (last_b !== (k == 3)) begin errs++; $display("FAIL msb8_last k=%0d got=%b exp=%b", k, last_b, k == 3); end
    end
    valid_i = 0;
  endtask
  task automatic test_jal;
    idle;
    cs_dec_i.add_sel = ADD_SEL_PC; cs_dec_i.en.jmp = 1; cs_dec_i.en.lsu_addr = 1;
    pc_i = 32'h100; imm_i = 32'h20; reg1_i = 32'h5555; valid_i = 1;
    #1;
    checks++; if ({jmp_a, jmp_b, br_a} !== 3'b110) begin errs++; $display("FAIL jal_strobe_c0 got=%b exp=110", {jmp_a, jmp_b, br_a}); end
    checks++; if (tgt_a !== 32'h120) begin errs++; $display("FAIL jal_target got=%h exp=120", tgt_a); end
    tick;
    checks++; if (lsu_a !== 32'h120) begin errs++; $display("FAIL jal_lsu got=%h exp=120", lsu_a); end
    checks++; if ({jmp_a, jmp_b} !== 2'b00) begin errs++; $display("FAIL jal_strobe_c1 got=%b exp=00", {jmp_a, jmp_b}); end
    valid_i = 0;
  endtask
  task automatic test_raw;
    idle;
    cs_dec_i.src_sel = SRC_REG; cs_dec_i.en.alu_a = 1; inst_i = 32'(5) << 7;
    cs_exe_i.en.rf_write = 1; reg1_i = 32'hAAAA5555; valid_i = 1;
    tick;
    checks++; if (rd_a !== 5'd5) begin errs++; $display("FAIL raw_rd got=%0d exp=5", rd_a); end
    tick;
    checks++; if (beat_a !== 16'hAAAA) begin errs++; $display("FAIL raw_inst1_beat1 got=%h exp=aaaa", beat_a); end
    inst_i = 32'(5) << 15; cs_exe_i = '0; reg1_i = 32'h12345678; ready_i = 0;
    tick;
    checks++; if (beat_a !== 16'hAAAA) begin errs++; $display("FAIL raw_ready_low_hold got=%h exp=aaaa", beat_a); end
    ready_i = 1;
    tick;
    checks++; if (beat_a !== 16'hAAAA) begin errs++; $display("FAIL raw_stall_hold got=%h exp=aaaa", beat_a); end
    tick;
    checks++; if ({beat_a, idx_a} !== {16'h5678, 1'b0}) begin errs++; $display("FAIL raw_resume_beat0 got=%h exp=%h", {beat_a, idx_a}, {16'h5678, 1'b0}); end
    tick;
    checks++; if ({beat_a, last_a} !== {16'h1234, 1'b1}) begin errs++; $display("FAIL raw_resume_beat1 got=%h exp=%h", {beat_a, last_a}, {16'h1234, 1'b1}); end
    valid_i = 0;
  endtask
  task automatic test_valid_drop;
    idle;
    cs_dec_i.src_sel = SRC_REG; cs_dec_i.en.alu_a = 1; reg1_i = 32'hA1B2C3D4; valid_i = 1;
    tick;
    checks++; if ({beat_b, idx_b} !== {8'hD4, 2'd0}) begin errs++; $display("FAIL drop_first got=%h exp=%h", {beat_b, idx_b}, {8'hD4, 2'd0}); end
    valid_i = 0;
    tick;
    checks++; if (beat_b !== 8'hD4) begin errs++; $display("FAIL drop_hold got=%h exp=d4", beat_b); end
    valid_i = 1;
    tick;
    checks++; if ({beat_b, idx_b} !== {8'hD4, 2'd0}) begin errs++; $display("FAIL drop_replay got=%h exp=%h", {beat_b, idx_b}, {8'hD4, 2'd0}); end
    tick;
    checks++; if ({beat_b, idx_b} !== {8'hC3, 2'd1}) begin errs++; $display("FAIL drop_next got=%h exp=%h", {beat_b, idx_b}, {8'hC3, 2'd1}); end
    valid_i = 0;
  endtask
  task automatic test_reset_mid;
    idle;
    cs_dec_i.src_sel = SRC_REG; cs_dec_i.en.alu_a = 1; cs_dec_i.en.lsu_addr = 1;
    cs_exe_i.en.rf_write = 1; inst_i = 32'(7) << 7; reg1_i = 32'hA1B2C3D4; imm_i = 32'h4; valid_i = 1;
    tick;
    tick;
    #2 rst_n = 0;
    #1;
    checks++; if ({beat_a, last_a} !== 17'h0) begin errs++; $display("FAIL midrst_a got=%h exp=0", {beat_a, last_a}); end
    checks++; if ({beat_b, idx_b, rd_b} !== 15'h0) begin errs++; $display("FAIL midrst_b got=%h exp=0", {beat_b, idx_b, rd_b}); end
    checks++; if ({lsu_b, exe_b} !== '0) begin errs++; $display("FAIL midrst_lsu_exe got=%h exp=0", {lsu_b, exe_b}); end
    #1 rst_n = 1;
    tick;
    checks++; if ({beat_b, idx_b} !== {8'hD4, 2'd0}) begin errs++; $display("FAIL midrst_first_beat got=%h exp=%h", {beat_b, idx_b}, {8'hD4, 2'd0}); end
    valid_i = 0;
  endtask
  typedef struct {
    int cnt; bit rq; logic [15:0] beat; int bidx; bit blast;
    exe_cs_s exe; logic [31:0] lsu; logic [4:0] rd, rs2, rs1q;
  } mstate_t;
  task automatic test_random;
    mstate_t m[2], nm[2];
    int nb[2], w[2], id, gi;
    logic [31:0] r, src, sh, etgt;
    logic [4:0] frs1, frs2;
    bit st, adv, lastb, er, ej, eb;
    logic [15:0] gb;
    nb = '{2, 4}; w = '{16, 8};
    tick;
    rst_n = 0;
    #2 rst_n = 1;
    for (int i = 0; i < 2; i++) m[i] = '{0, 0, '0, 0, 0, '0, '0, '0, '0, '0};
    for (int n = 0; n < 400; n++) begin
      valid_i = $urandom_range(0, 7) != 0;
      ready_i = $urandom_range(0, 3) != 0;
      inst_i = $urandom;
      inst_i[11:7] = 5'($urandom_range(0, 3));
      inst_i[19:15] = 5'($urandom_range(0, 3));
      inst_i[24:20] = 5'($urandom_range(0, 3));
      pc_i = $urandom; reg1_i = $urandom; imm_i = $urandom;
      r = $urandom; cs_dec_i = r[$bits(dec_cs_s)-1:0];
      cs_dec_i.src_sel = ser_src_e'($urandom_range(0, 2));
      r = $urandom; cs_exe_i = r[$bits(exe_cs_s)-1:0];
      #1;
      frs1 = inst_i[19:15]; frs2 = inst_i[24:20];
      src = cs_dec_i.src_sel == SRC_IMM ? imm_i : cs_dec_i.src_sel == SRC_PC ? pc_i : reg1_i;
      etgt = (cs_dec_i.add_sel == ADD_SEL_PC ? pc_i : reg1_i) + imm_i;
      for (int i = 0; i < 2; i++) begin
        st = !m[i].rq && ((cs_dec_i.en.load_bypass && !m[i].exe.en.dmem_store) ||
             (m[i].exe.en.rf_write && m[i].rd == frs1 && frs1 != 0) ||
             (cs_dec_i.en.alu_a && m[i].exe.en.wb_order_flip && m[i].rd == frs2));
        adv = valid_i && ready_i && !st;
        lastb = m[i].cnt == nb[i] - 1;
        er = adv && lastb;
        ej = valid_i && m[i].cnt == 0 && cs_dec_i.en.jmp;
        eb = valid_i && m[i].cnt == 0 && cs_dec_i.en.branch;
        checks++; if ((i == 0 ? ready_a : ready_b) !== er) begin errs++; $display("FAIL rnd_ready n=%0d i=%0d exp=%b", n, i, er); end
        checks++; if ((i == 0 ? {jmp_a, br_a} : {jmp_b, br_b}) !== {ej, eb}) begin errs++; $display("FAIL rnd_jmp_br n=%0d i=%0d exp=%b%b", n, i, ej, eb); end
        checks++; if ((i == 0 ? tgt_a : tgt_b) !== etgt) begin errs++; $display("FAIL rnd_target n=%0d i=%0d exp=%h", n, i, etgt); end
        checks++; if ((i == 0 ? rs1_a : rs1_b) !== (cs_dec_i.en.reg_use ? frs1 : m[i].rs1q)) begin errs++; $display("FAIL rnd_rs1 n=%0d i=%0d", n, i); end
        checks++; if ((i == 0 ? valid_a : valid_b) !== valid_i) begin errs++; $display("FAIL rnd_valid n=%0d i=%0d exp=%b", n, i, valid_i); end
        nm[i] = m[i];
        nm[i].rq = ready_i;
        if (cs_dec_i.en.reg_use) nm[i].rs1q = frs1;
        nm[i].cnt = !valid_i ? 0 : !adv ? m[i].cnt : lastb ? 0 : m[i].cnt + 1;
        if (adv) begin
          nm[i].exe = cs_exe_i;
          if (cs_dec_i.en.alu_a || cs_dec_i.en.wb) begin
            id = cs_dec_i.msb_first ? nb[i] - 1 - m[i].cnt : m[i].cnt;
            sh = src >> (id * w[i]);
            nm[i].beat = w[i] == 16 ? sh[15:0] : {8'h0, sh[7:0]};
            nm[i].bidx = id;
            nm[i].blast = lastb;
          end
          if (m[i].cnt == 0) begin
            if (cs_dec_i.en.lsu_addr) nm[i].lsu = etgt;
            if (cs_exe_i.en.rf_write) nm[i].rd = inst_i[11:7];
            if (cs_dec_i.en.alu_a) nm[i].rs2 = frs2;
          end
        end
      end
      tick;
      m = nm;
      for (int i = 0; i < 2; i++) begin
        gb = i == 0 ? beat_a : {8'h0, beat_b};
        gi = i == 0 ? int'(idx_a) : int'(idx_b);
        checks++; if (gb !== m[i].beat) begin errs++; $display("FAIL rnd_beat n=%0d i=%0d got=%h exp=%h", n, i, gb, m[i].beat); end
        checks++; if (gi != m[i].bidx) begin errs++; $display("FAIL rnd_idx n=%0d i=%0d got=%0d exp=%0d", n, i, gi, m[i].bidx); end
        checks++; if ((i == 0 ? last_a : last_b) !== m[i].blast) begin errs++; $display("FAIL rnd_last n=%0d i=%0d exp=%b", n, i, m[i].blast); end
        checks++; if ((i == 0 ? exe_a : exe_b) !== m[i].exe) begin errs++; $display("FAIL rnd_exe n=%0d i=%0d exp=%h", n, i, m[i].exe); end
        checks++; if ((i == 0 ? lsu_a : lsu_b) !== m[i].lsu) begin errs++; $display("FAIL rnd_lsu n=%0d i=%0d exp=%h", n, i, m[i].lsu); end
        checks++; if ((i == 0 ? {rd_a, rs2_a} : {rd_b, rs2_b}) !== {m[i].rd, m[i].rs2}) begin errs++; $display("FAIL rnd_rd_rs2 n=%0d i=%0d exp=%h", n, i, {m[i].rd, m[i].rs2}); end
      end
    end
    valid_i = 0;
  endtask
  initial begin
    test_reset;
    test_lsb16;
    test_msb8;
    test_jal;
    test_raw;
    test_valid_drop;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
